haar_stage_evaluator: RTL and testbench
=======================================

# haar_stage_evaluator

Consumer end of the per-stage classifier database stream in the face-detection pipeline. Requests and parses the 12-bit parameter words of one Haar stage, fetches rectangle sums through a request/acknowledge port to the integral-image store, and accumulates the weak-classifier votes. Compares the total against the stage threshold and reports a pass/fail verdict for the current window. One instance sits behind each stage database in the second-phase cascade.

## Interface
- `DATA_WIDTH_12`, 12: parameter word width; all words are signed two's complement unless noted.
- `ADDR_WIDTH`, 12: width of the classifier counter.
- `NUM_PARAM_PER_CLASSIFIER`, 18: words per classifier.
- `NUM_STAGE_THRESHOLD`, 3: stage-threshold words after the last classifier.
- `SUM_WIDTH`, 20: unsigned rectangle-sum width.
- `FEAT_WIDTH`, 36: signed feature accumulator width.
- `ACC_WIDTH`, 24: signed stage accumulator width.
- `THR_SHIFT`, 4: left shift applied to the classifier threshold before comparison.

Ports:
- `clk_fpga` in 1: single clock.
- `reset_fpga` in 1: synchronous, active-low reset.
- `i_start` in 1: one-cycle pulse; begins evaluation of one window.
- `o_rden` out 1: word request to the database; high only in LOAD and STHR.
- `i_valid` in 1: `i_data` is valid this cycle.
- `i_data` in 12: parameter word.
- `i_end_single_classifier` in 1: marks the last word of a classifier.
- `i_end_all_classifier` in 1: marks the last word of the last classifier.
- `i_end_database` in 1: marks the last stage-threshold word.
- `o_rect_req` out 1: rectangle-sum request.
- `o_rect_x`, `o_rect_y`, `o_rect_w`, `o_rect_h` out 12 each: rectangle geometry (unsigned).
- `i_rect_ack` in 1: request accepted; `i_rect_sum` is valid this cycle.
- `i_rect_sum` in SUM_WIDTH: unsigned rectangle sum.
- `o_busy` out 1: state is not IDLE.
- `o_done` out 1: one-cycle pulse when the verdict is valid.
- `o_pass` out 1: stage passed; held until the next `i_start`.
- `o_num_classifiers` out ADDR_WIDTH: number of classifiers evaluated.
- `o_err` out 1: sticky protocol error; cleared by reset or `i_start`.

## Operation
Classifier word layout, words 0–17:
- Rect k, k=0..2, occupies words 5k..5k+4: x, y, w, h, weight.
- Word 15: threshold.
- Word 16: left value.
- Word 17: right value.

Stage-threshold words: word 0 bit0 is the sign; word 1 holds magnitude[23:12]; word 2 holds magnitude[11:0].

States:
- **IDLE**
  - `i_start` → LOAD; clears the stage accumulator, classifier count, `o_pass` and `o_err`.
  - `i_start` in any other state is ignored.
- **LOAD**
  - Captures `i_data` into parameter register [idx] on each `i_valid` cycle and increments idx.
  - On idx=17: sets `o_err` if `i_end_single_classifier` is low, latches `i_end_all_classifier` as a last flag, then → RECT.
  - `i_end_single_classifier` on any idx≠17 sets `o_err`, and the classifier is discarded → LOAD (idx=0).
- **RECT**
  - Clears the feature accumulator on entry.
  - For k=0,1,2: drives `o_rect_req` with the rect-k geometry, held stable until `i_rect_ack`.
  - On ack: feature += sign_extend(weight_k) × zero_extend(`i_rect_sum`).
  - Rect 2 is skipped when its weight is 0.
  - After the last rect → ACCUM.
- **ACCUM**
  - If feature < (sign_extend(threshold) <<< THR_SHIFT), stage += left; else stage += right. Both values are sign-extended to ACC_WIDTH.
  - Classifier count +1.
  - If the last flag is set → STHR, else → LOAD.
- **STHR**
  - Captures 3 words.
  - On word 2: `o_err` is set if `i_end_database` is low. → DONE.
- **DONE**
  - `o_done`=1 for one cycle.
  - `o_pass` = (stage ≥ signed stage threshold).
  - → IDLE.

Protocol rules:
- `i_valid` outside LOAD or STHR sets `o_err`; the word is dropped.
- `i_rect_ack` without `o_rect_req` is ignored.

Arithmetic rules:
- The stage accumulator wraps; no saturation.
- The feature accumulator is sized so it cannot overflow for 3 rects.

## Timing
Reset values: all outputs are 0, the state is IDLE, idx is 0 and both accumulators are 0.

Cycle-level behaviour:
- `o_rden` rises the cycle after `i_start` is sampled.
- LOAD takes a minimum of 18 cycles per classifier.
- `o_rden` drops on the cycle after word 17 is captured.
- RECT takes one cycle per rect with immediate ack. `o_rect_req` is registered, and a new geometry is presented the cycle after an ack.
- ACCUM takes 1 cycle.

Minimum per classifier: 18 + 3 + 1 = 22 cycles, or 21 with rect 2 skipped. The `o_done` pulse comes 1 cycle after the last threshold word.

Boundary conditions:
- `i_end_single_classifier` and `i_end_all_classifier` together on word 17: legal; this is the normal end of the last classifier.
- Reset mid-operation: IDLE on the next edge, with `o_rden` and `o_rect_req` low.

## Structure
- Shared package `haar_pkg` holds:
  - the state enum;
  - word-offset constants (RECT_STRIDE=5, OFF_THR=15, OFF_LEFT=16, OFF_RIGHT=17);
  - the stage-threshold word layout.
- One sub-module, `haar_rect_mac`: the request/ack sequencer plus the multiply-accumulate over rects 0–2, including the zero-weight skip. The FSM and stage accumulator stay in the top.

## Test plan
- **One classifier passes:**
  - Stimulus: weights (-1, 2, 0); sums 100, 80; threshold 3; left -5, right 7; stage threshold +6.
  - Feature 60 ≥ 48, so right is added and stage = 7 → `o_pass`=1, `o_num_classifiers`=1, exactly 2 rect requests.
- **Same classifier with stage threshold +8:** → `o_pass`=0 and `o_done` pulses once.
- **Negative feature:**
  - Stimulus: weights (-3, 1); sums 50, 10.
  - Feature -140 < 48, so stage += left (-5); stage threshold sign=1, magnitude 5 → `o_pass`=1.
- **Ack backpressure:** `i_rect_ack` delayed 4 cycles per rect → geometry stays stable and the result is identical to immediate ack.
- **Protocol error:** `i_end_single_classifier` on word 9 → `o_err`=1; the classifier is discarded and `o_num_classifiers` does not include it.
- **Reset mid-RECT:** `reset_fpga`=0 while `o_rect_req`=1 → next cycle all outputs 0; a new `i_start` evaluates cleanly.

Source files
------------

// File: rtl/haar_pkg.sv
// Shared definitions for the Haar stage evaluator: FSM states, classifier word
// offsets and the stage-threshold word layout.
package haar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RECT,
    ST_ACCUM,
    ST_STHR,
    ST_DONE
  } state_t;

  localparam int NUM_RECTS   = 3;
  localparam int RECT_STRIDE = 5;
  localparam int OFF_X       = 0;
  localparam int OFF_Y       = 1;
  localparam int OFF_W       = 2;
  localparam int OFF_H       = 3;
  localparam int OFF_WEIGHT  = 4;
  localparam int OFF_THR     = 15;
  localparam int OFF_LEFT    = 16;
  localparam int OFF_RIGHT   = 17;

  // Stage threshold: sign in word 0 bit 0, magnitude split hi/lo over words 1/2
  localparam int STHR_SIGN_WORD = 0;
  localparam int STHR_HI_WORD   = 1;
  localparam int STHR_LO_WORD   = 2;
  localparam int STHR_VAL_W     = 26;

  function automatic logic signed [STHR_VAL_W-1:0] sthr_value(
    input logic        sign_bit,
    input logic [11:0] hi,
    input logic [11:0] lo
  );
    logic signed [STHR_VAL_W-1:0] mag;
    mag = $signed({2'b00, hi, lo});
    return sign_bit ? -mag : mag;
  endfunction

endpackage

// File: rtl/haar_stage_evaluator_if.sv
// Database stream, rectangle-sum port and status signals of one stage evaluator.
interface haar_stage_evaluator_if #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int ADDR_WIDTH    = 12,
  parameter int SUM_WIDTH     = 20
);
  logic                     i_start;
  logic                     o_rden;
  logic                     i_valid;
  logic [DATA_WIDTH_12-1:0] i_data;
  logic                     i_end_single_classifier;
  logic                     i_end_all_classifier;
  logic                     i_end_database;
  logic                     o_rect_req;
  logic [DATA_WIDTH_12-1:0] o_rect_x;
  logic [DATA_WIDTH_12-1:0] o_rect_y;
  logic [DATA_WIDTH_12-1:0] o_rect_w;
  logic [DATA_WIDTH_12-1:0] o_rect_h;
  logic                     i_rect_ack;
  logic [SUM_WIDTH-1:0]     i_rect_sum;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_pass;
  logic [ADDR_WIDTH-1:0]    o_num_classifiers;
  logic                     o_err;

  // master: the evaluator; slave: database, integral-image store and controller
  modport master (
    input  i_start, i_valid, i_data, i_end_single_classifier, i_end_all_classifier,
           i_end_database, i_rect_ack, i_rect_sum,
    output o_rden, o_rect_req, o_rect_x, o_rect_y, o_rect_w, o_rect_h,
           o_busy, o_done, o_pass, o_num_classifiers, o_err
  );

  modport slave (
    output i_start, i_valid, i_data, i_end_single_classifier, i_end_all_classifier,
           i_end_database, i_rect_ack, i_rect_sum,
    input  o_rden, o_rect_req, o_rect_x, o_rect_y, o_rect_w, o_rect_h,
           o_busy, o_done, o_pass, o_num_classifiers, o_err
  );
endinterface

// File: rtl/haar_rect_mac.sv
// Rectangle request/ack sequencer with weighted multiply-accumulate over the
// three rects of one classifier; rect 2 is skipped when its weight is zero.
module haar_rect_mac
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH_12 = 12,
  parameter int SUM_WIDTH     = 20,
  parameter int FEAT_WIDTH    = 36
) (
  input  logic                                          clk_fpga,
  input  logic                                          reset_fpga,
  input  logic                                          start,
  input  logic [NUM_RECTS-1:0][3:0][DATA_WIDTH_12-1:0]  geom,
  input  logic [NUM_RECTS-1:0][DATA_WIDTH_12-1:0]       weight,
  output logic                                          rect_req,
  output logic [DATA_WIDTH_12-1:0]                      rect_x,
  output logic [DATA_WIDTH_12-1:0]                      rect_y,
  output logic [DATA_WIDTH_12-1:0]                      rect_w,
  output logic [DATA_WIDTH_12-1:0]                      rect_h,
  input  logic                                          rect_ack,
  input  logic [SUM_WIDTH-1:0]                          rect_sum,
  output logic                                          fin,
  output logic signed [FEAT_WIDTH-1:0]                  feature
);
  localparam int PW = DATA_WIDTH_12 + SUM_WIDTH + 1;

  logic                        req_q;
  logic [1:0]                  k_q;
  logic signed [FEAT_WIDTH-1:0] feature_q;
  logic signed [PW-1:0]        weight_ext;
  logic signed [PW-1:0]        sum_ext;
  logic signed [PW-1:0]        product;
  logic                        accept;
  logic                        last_rect;

  assign weight_ext = $signed({{(PW-DATA_WIDTH_12){weight[k_q][DATA_WIDTH_12-1]}}, weight[k_q]});
  assign sum_ext    = $signed({{(PW-SUM_WIDTH){1'b0}}, rect_sum});
  assign product    = weight_ext * sum_ext;

  assign accept    = req_q && rect_ack;
  assign last_rect = (k_q == 2'd2) || (k_q == 2'd1 && weight[2] == '0);
  assign fin       = accept && last_rect;

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      req_q     <= 1'b0;
      k_q       <= 2'd0;
      feature_q <= '0;
    end else if (start) begin
      req_q     <= 1'b1;
      k_q       <= 2'd0;
      feature_q <= '0;
    end else if (accept) begin
      feature_q <= feature_q + {{(FEAT_WIDTH-PW){product[PW-1]}}, product};
      if (last_rect) begin
        req_q <= 1'b0;
        k_q   <= 2'd0;
      end else begin
        k_q <= k_q + 2'd1;
      end
    end
  end

  // Geometry reads zero whenever no request is outstanding
  assign rect_req = req_q;
  assign rect_x   = req_q ? geom[k_q][0] : '0;
  assign rect_y   = req_q ? geom[k_q][1] : '0;
  assign rect_w   = req_q ? geom[k_q][2] : '0;
  assign rect_h   = req_q ? geom[k_q][3] : '0;
  assign feature  = feature_q;

endmodule

// File: rtl/haar_stage_evaluator.sv
// One Haar cascade stage: parses classifier words, sums weighted rect votes and
// compares the stage total against the stage threshold.
module haar_stage_evaluator
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH_12            = 12,
  parameter int ADDR_WIDTH               = 12,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_STAGE_THRESHOLD      = 3,
  parameter int SUM_WIDTH                = 20,
  parameter int FEAT_WIDTH               = 36,
  parameter int ACC_WIDTH                = 24,
  parameter int THR_SHIFT                = 4
) (
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  haar_stage_evaluator_if.master bus
);
  localparam int DW = DATA_WIDTH_12;

  state_t                      state_q, state_d;
  logic [4:0]                  idx_q;
  logic                        last_q;
  logic signed [ACC_WIDTH-1:0] stage_q;
  logic [ADDR_WIDTH-1:0]       count_q;
  logic                        pass_q;
  logic                        err_q;
  logic [DW-1:0]               params_q [NUM_PARAM_PER_CLASSIFIER];
  logic                        sthr_sign_q;
  logic [DW-1:0]               sthr_hi_q;

  logic [NUM_RECTS-1:0][3:0][DW-1:0] geom;
  logic [NUM_RECTS-1:0][DW-1:0]      weight;
  logic                         mac_start;
  logic                         mac_fin;
  logic signed [FEAT_WIDTH-1:0] feature;
  logic signed [FEAT_WIDTH-1:0] thr_scaled;
  logic signed [ACC_WIDTH-1:0]  vote;
  logic signed [STHR_VAL_W-1:0] sthr_val;
  logic signed [STHR_VAL_W-1:0] stage_ext;
  logic                         word_last;
  logic                         sthr_last;

  assign word_last = idx_q == 5'(NUM_PARAM_PER_CLASSIFIER - 1);
  assign sthr_last = idx_q == 5'(NUM_STAGE_THRESHOLD - 1);

  always_comb begin
    for (int k = 0; k < NUM_RECTS; k++) begin
      geom[k][0] = params_q[k*RECT_STRIDE + OFF_X];
      geom[k][1] = params_q[k*RECT_STRIDE + OFF_Y];
      geom[k][2] = params_q[k*RECT_STRIDE + OFF_W];
      geom[k][3] = params_q[k*RECT_STRIDE + OFF_H];
      weight[k]  = params_q[k*RECT_STRIDE + OFF_WEIGHT];
    end
  end

  assign thr_scaled = $signed({{(FEAT_WIDTH-DW){params_q[OFF_THR][DW-1]}}, params_q[OFF_THR]}) <<< THR_SHIFT;
  assign vote = (feature < thr_scaled)
              ? $signed({{(ACC_WIDTH-DW){params_q[OFF_LEFT][DW-1]}}, params_q[OFF_LEFT]})
              : $signed({{(ACC_WIDTH-DW){params_q[OFF_RIGHT][DW-1]}}, params_q[OFF_RIGHT]});
  assign sthr_val  = sthr_value(sthr_sign_q, sthr_hi_q, bus.i_data);
  assign stage_ext = $signed({{(STHR_VAL_W-ACC_WIDTH){stage_q[ACC_WIDTH-1]}}, stage_q});

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mac_start = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bus.i_start) state_d = ST_LOAD;
      ST_LOAD:  if (bus.i_valid && word_last) begin
                  state_d   = ST_RECT;
                  mac_start = 1'b1;
                end
      ST_RECT:  if (mac_fin) state_d = ST_ACCUM;
      ST_ACCUM: state_d = last_q ? ST_STHR : ST_LOAD;
      ST_STHR:  if (bus.i_valid && sthr_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Parameter words carry no reset; they are always rewritten before use
  always_ff @(posedge clk_fpga) begin
    if (state_q == ST_LOAD && bus.i_valid) params_q[idx_q] <= bus.i_data;
    if (state_q == ST_STHR && bus.i_valid) begin
      if (idx_q == 5'(STHR_SIGN_WORD)) sthr_sign_q <= bus.i_data[0];
      if (idx_q == 5'(STHR_HI_WORD))   sthr_hi_q   <= bus.i_data;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (!reset_fpga) begin
      idx_q   <= '0;
      last_q  <= 1'b0;
      stage_q <= '0;
      count_q <= '0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            idx_q   <= '0;
            stage_q <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
          end else if (bus.i_valid) begin
            err_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (bus.i_valid) begin
            if (word_last) begin
              idx_q  <= '0;
              last_q <= bus.i_end_all_classifier;
              if (!bus.i_end_single_classifier) err_q <= 1'b1;
            end else if (bus.i_end_single_classifier) begin
              idx_q <= '0;
              err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        ST_ACCUM: begin
          stage_q <= stage_q + vote;
          count_q <= count_q + ADDR_WIDTH'(1);
          if (bus.i_valid) err_q <= 1'b1;
        end
        ST_STHR: begin
          if (bus.i_valid) begin
            if (sthr_last) begin
              idx_q  <= '0;
              pass_q <= stage_ext >= sthr_val;
              if (!bus.i_end_database) err_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        default: if (bus.i_valid) err_q <= 1'b1;
      endcase
    end
  end

  haar_rect_mac #(
    .DATA_WIDTH_12 (DW),
    .SUM_WIDTH     (SUM_WIDTH),
    .FEAT_WIDTH    (FEAT_WIDTH)
  ) u_mac (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .start      (mac_start),
    .geom       (geom),
    .weight     (weight),
    .rect_req   (bus.o_rect_req),
    .rect_x     (bus.o_rect_x),
    .rect_y     (bus.o_rect_y),
    .rect_w     (bus.o_rect_w),
    .rect_h     (bus.o_rect_h),
    .rect_ack   (bus.i_rect_ack),
    .rect_sum   (bus.i_rect_sum),
    .fin        (mac_fin),
    .feature    (feature)
  );

  assign bus.o_rden            = (state_q == ST_LOAD) || (state_q == ST_STHR);
  assign bus.o_busy            = state_q != ST_IDLE;
  assign bus.o_done            = state_q == ST_DONE;
  assign bus.o_pass            = pass_q;
  assign bus.o_err             = err_q;
  assign bus.o_num_classifiers = count_q;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Directed bench for haar_stage_evaluator: vector table of single/double
// classifier windows plus hand sequences for protocol error and mid-RECT reset.
module tb_haar_stage_evaluator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  haar_stage_evaluator_if bus();

  haar_stage_evaluator dut (
    .clk_fpga   (clk),
    .reset_fpga (rst_n),
    .bus        (bus)
  );

  typedef struct {
    int w0, w1, w2;
    int s0, s1, s2;
    int thr, left, right;
    int sgn, mag;
    int dly, ncls;
    int exp_pass;
  } vec_t;

  vec_t vecs [9];
  int   n_cmp = 0;
  int   n_bad = 0;

  // responder state
  int cur_dly = 0;
  int cur_sum [3];
  int rect_k = 0;
  int wait_cnt = 0;
  int ack_total = 0;
  bit resp_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint exp_geom(input int k);
    logic [11:0] x, y, w, h;
    x = 12'(16 + k); y = 12'(32 + k); w = 12'(4 + 2*k); h = 12'(6 + k);
    return longint'({x, y, w, h});
  endfunction

  always @(posedge clk) begin
    #1;
    bus.i_rect_ack = 1'b0;
    if (!bus.o_rect_req) begin
      wait_cnt = 0;
      rect_k   = 0;
    end else if (resp_en && rect_k < 3) begin
      chk("rect_geom", longint'({bus.o_rect_x, bus.o_rect_y, bus.o_rect_w, bus.o_rect_h}),
          exp_geom(rect_k));
      if (wait_cnt >= cur_dly) begin
        bus.i_rect_ack = 1'b1;
        bus.i_rect_sum = 20'(cur_sum[rect_k]);
        ack_total++;
        rect_k++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rden();
    int n = 0;
    while (!bus.o_rden && n < 200) begin
      tick();
      n++;
    end
    chk("rden_wait", longint'(bus.o_rden), 1);
  endtask

  task automatic setup(input vec_t v);
    cur_dly    = v.dly;
    cur_sum[0] = v.s0;
    cur_sum[1] = v.s1;
    cur_sum[2] = v.s2;
    ack_total  = 0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("rden_after_start", longint'(bus.o_rden), 1);
  endtask

  task automatic feed_class(input vec_t v, input bit last);
    logic [11:0] w [18];
    int wt [3];
    wt[0] = v.w0; wt[1] = v.w1; wt[2] = v.w2;
    for (int k = 0; k < 3; k++) begin
      w[5*k]   = 12'(16 + k);
      w[5*k+1] = 12'(32 + k);
      w[5*k+2] = 12'(4 + 2*k);
      w[5*k+3] = 12'(6 + k);
      w[5*k+4] = 12'(wt[k]);
    end
    w[15] = 12'(v.thr); w[16] = 12'(v.left); w[17] = 12'(v.right);
    for (int i = 0; i < 18; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = w[i];
      bus.i_end_single_classifier = (i == 17);
      bus.i_end_all_classifier    = (i == 17) && last;
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_end_single_classifier = 1'b0;
    bus.i_end_all_classifier    = 1'b0;
    chk("rden_drop", longint'(bus.o_rden), 0);
    chk("req_rise", longint'(bus.o_rect_req), 1);
  endtask

  task automatic feed_sthr(input vec_t v);
    logic [11:0] w [3];
    w[0] = 12'(v.sgn & 1);
    w[1] = 12'((v.mag >> 12) & 'hfff);
    w[2] = 12'(v.mag & 'hfff);
    wait_rden();
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = w[i];
      bus.i_end_database = (i == 2);
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_end_database = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int reqs;
    reqs = (v.w2 == 0) ? 2 : 3;
    setup(v);
    resp_en = 1'b1;
    pulse_start();
    for (int c = 0; c < v.ncls; c++) begin
      wait_rden();
      feed_class(v, c == v.ncls - 1);
    end
    feed_sthr(v);
    chk($sformatf("v%0d_done", id), longint'(bus.o_done), 1);
    chk($sformatf("v%0d_pass", id), longint'(bus.o_pass), v.exp_pass);
    chk($sformatf("v%0d_count", id), longint'(bus.o_num_classifiers), v.ncls);
    chk($sformatf("v%0d_err", id), longint'(bus.o_err), 0);
    chk($sformatf("v%0d_reqs", id), ack_total, v.ncls * reqs);
    tick();
    chk($sformatf("v%0d_done_once", id), longint'(bus.o_done), 0);
    chk($sformatf("v%0d_idle", id), longint'(bus.o_busy), 0);
    chk($sformatf("v%0d_pass_hold", id), longint'(bus.o_pass), v.exp_pass);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rden"}, longint'(bus.o_rden), 0);
    chk({tag, "_req"}, longint'(bus.o_rect_req), 0);
    chk({tag, "_geom"}, longint'({bus.o_rect_x, bus.o_rect_y, bus.o_rect_w, bus.o_rect_h}), 0);
    chk({tag, "_busy"}, longint'(bus.o_busy), 0);
    chk({tag, "_done"}, longint'(bus.o_done), 0);
    chk({tag, "_pass"}, longint'(bus.o_pass), 0);
    chk({tag, "_err"}, longint'(bus.o_err), 0);
    chk({tag, "_count"}, longint'(bus.o_num_classifiers), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_end_single_classifier = 1'b0;
    bus.i_end_all_classifier    = 1'b0;
    bus.i_end_database          = 1'b0;
    bus.i_rect_ack = 1'b0;
    bus.i_rect_sum = '0;

    //             w0  w1  w2   s0   s1 s2  thr  left right sgn  mag  dly ncls pass
    vecs[0] = '{-1,  2,  0,  100,  80, 0,   3,   -5,   7,  0,    6,  0,  1,  1};
    vecs[1] = '{-1,  2,  0,  100,  80, 0,   3,   -5,   7,  0,    8,  0,  1,  0};
    vecs[2] = '{-3,  1,  0,   50,  10, 0,   3,   -5,   7,  1,    5,  0,  1,  1};
    vecs[3] = '{-1,  2,  0,  100,  80, 0,   3,   -5,   7,  0,    6,  4,  1,  1};
    vecs[4] = '{ 1,  1, -2,   10,  20, 5,   1,    3,  -4,  1,    4,  2,  1,  1};
    vecs[5] = '{ 4,  0,  0, 1000,   7, 0, 200,   -1, 2047, 0, 2048,  0,  1,  0};
    vecs[6] = '{-1,  0,  0,    5,   9, 0,   0, -2048,  5,  1, 4096,  0,  1,  1};
    vecs[7] = '{-1,  2,  0,  100,  80, 0,   3,   -5,   7,  0,   14,  0,  2,  1};
    vecs[8] = '{-1,  2,  0,  100,  80, 0,   3,   -5,   7,  0,   15,  0,  2,  0};

    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Stray word while idle flags an error; the next start clears it
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    chk("idle_valid_err", longint'(bus.o_err), 1);
    run_vec(9, vecs[0]);

    // Early end-of-classifier on word 9 discards the classifier
    setup(vecs[0]);
    resp_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 12'(i + 1);
      bus.i_end_single_classifier = (i == 9);
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_end_single_classifier = 1'b0;
    chk("early_end_err", longint'(bus.o_err), 1);
    chk("early_end_rden", longint'(bus.o_rden), 1);
    feed_class(vecs[0], 1'b1);
    feed_sthr(vecs[0]);
    chk("early_end_done", longint'(bus.o_done), 1);
    chk("early_end_count", longint'(bus.o_num_classifiers), 1);
    chk("early_end_pass", longint'(bus.o_pass), 1);
    chk("early_end_err_sticky", longint'(bus.o_err), 1);
    tick();

    // Reset while a rect request of the second classifier is outstanding
    setup(vecs[0]);
    resp_en = 1'b1;
    pulse_start();
    feed_class(vecs[0], 1'b0);
    wait_rden();
    resp_en = 1'b0;
    feed_class(vecs[0], 1'b1);
    tick();
    chk("midrect_req_held", longint'(bus.o_rect_req), 1);
    chk("midrect_count", longint'(bus.o_num_classifiers), 1);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    chk("midrect_err", longint'(bus.o_err), 1);
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrect_reset");
    rst_n = 1'b1;
    tick();
    run_vec(10, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
